// File: rtl/e203_eai_csr_slv.sv
// EAI CSR responder: control, scratch, 64-bit cycle counter, multi-cycle accumulator
// and a saturating counter of accesses that hit no register.
module e203_eai_csr_slv #(
    parameter int unsigned ACC_LAT = 3,
    parameter int unsigned XLEN    = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cfg_xs_off,
    output logic            eai_xs_off,
    input  logic            eai_csr_valid,
    output logic            eai_csr_ready,
    input  logic [11:0]     eai_csr_addr,
    input  logic            eai_csr_wr,
    input  logic [XLEN-1:0] eai_csr_wdata,
    output logic [XLEN-1:0] eai_csr_rdata,
    output logic            acc_busy
);

    typedef enum logic {IDLE, BUSY} state_e;

    localparam logic [7:0] A_ECTL    = 8'h00;
    localparam logic [7:0] A_SCR0    = 8'h02;
    localparam logic [7:0] A_SCR1    = 8'h03;
    localparam logic [7:0] A_SCR2    = 8'h04;
    localparam logic [7:0] A_SCR3    = 8'h05;
    localparam logic [7:0] A_ECYCLE  = 8'h08;
    localparam logic [7:0] A_ECYCLEH = 8'h09;
    localparam logic [7:0] A_EACC    = 8'h0A;
    localparam logic [7:0] A_ERRCNT  = 8'h0B;

    localparam logic [3:0] CNT_INIT = 4'(ACC_LAT - 1);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [XLEN-1:0]   addend_q, addend_d;
    logic [XLEN-1:0]   acc_q, acc_d;
    logic              cnt_en_q, cnt_en_d;
    logic [XLEN-1:0]   scr_q [4];
    logic [XLEN-1:0]   scr_d [4];
    logic [63:0]       cyc_q, cyc_d;
    logic [XLEN-1:0]   errcnt_q, errcnt_d;
    logic              xs_off_q;

    logic [7:0] idx;
    logic       hs;
    logic       wr_hs;
    logic       mapped;

    assign idx   = eai_csr_addr[7:0];
    assign hs    = eai_csr_valid & eai_csr_ready;
    assign wr_hs = hs & eai_csr_wr;

    // Ready is a pure function of state so the initiator never sees a comb loop.
    assign eai_csr_ready = (state_q == IDLE);
    assign acc_busy      = (state_q == BUSY);
    assign eai_xs_off    = xs_off_q;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
        mapped = 1'b0;
        if (eai_csr_addr[11:8] == 4'hE) begin
            case (idx)
                A_ECTL, A_SCR0, A_SCR1, A_SCR2, A_SCR3,
                A_ECYCLE, A_ECYCLEH, A_EACC, A_ERRCNT: mapped = 1'b1;
                default:                               mapped = 1'b0;
            endcase
        end
    end

    always_comb begin
        eai_csr_rdata = '0;
        if (eai_csr_valid && mapped) begin
            case (idx)
                A_ECTL:    eai_csr_rdata = {{(XLEN-1){1'b0}}, cnt_en_q};
                A_SCR0:    eai_csr_rdata = scr_q[0];
                A_SCR1:    eai_csr_rdata = scr_q[1];
                A_SCR2:    eai_csr_rdata = scr_q[2];
                A_SCR3:    eai_csr_rdata = scr_q[3];
                A_ECYCLE:  eai_csr_rdata = cyc_q[31:0];
                A_ECYCLEH: eai_csr_rdata = cyc_q[63:32];
                A_EACC:    eai_csr_rdata = acc_q;
                A_ERRCNT:  eai_csr_rdata = errcnt_q;
                default:   eai_csr_rdata = '0;
            endcase
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addend_d = addend_q;
        acc_d    = acc_q;
        cnt_en_d = cnt_en_q;
        scr_d    = scr_q;
        cyc_d    = cyc_q;
        errcnt_d = errcnt_q;

        if (cnt_en_q) cyc_d = cyc_q + 64'd1;

        // A half-load replaces the increment entirely: no carry into the other half.
        if (wr_hs && mapped) begin
            case (idx)
                A_ECTL:    cnt_en_d = eai_csr_wdata[0];
                A_SCR0:    scr_d[0] = eai_csr_wdata;
                A_SCR1:    scr_d[1] = eai_csr_wdata;
                A_SCR2:    scr_d[2] = eai_csr_wdata;
                A_SCR3:    scr_d[3] = eai_csr_wdata;
                A_ECYCLE:  cyc_d    = {cyc_q[63:32], eai_csr_wdata};
                A_ECYCLEH: cyc_d    = {eai_csr_wdata, cyc_q[31:0]};
                default:   ;
            endcase
        end

        if (hs && !mapped && (errcnt_q != '1)) errcnt_d = errcnt_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (wr_hs && mapped && (idx == A_EACC)) begin
                    addend_d = eai_csr_wdata;
                    cnt_d    = CNT_INIT;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    acc_d   = acc_q + addend_q;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addend_q <= '0;
            acc_q    <= '0;
            cnt_en_q <= 1'b0;
            // NOTE: the scratch file is architecturally visible after reset, so each entry is cleared.
            for (int i = 0; i < 4; i++) scr_q[i] <= '0;
            cyc_q    <= '0;
            errcnt_q <= '0;
            xs_off_q <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addend_q <= addend_d;
            acc_q    <= acc_d;
            cnt_en_q <= cnt_en_d;
            for (int i = 0; i < 4; i++) scr_q[i] <= scr_d[i];
            cyc_q    <= cyc_d;
            errcnt_q <= errcnt_d;
            xs_off_q <= cfg_xs_off;
        end
    end

endmodule

// File: tb/tb_e203_eai_csr_slv.sv
// Directed bench for e203_eai_csr_slv (ACC_LAT=3): one drive() call per clock cycle,
// outputs sampled mid-cycle after the negedge drive.
module tb_e203_eai_csr_slv;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_xs_off;
    logic        eai_xs_off;
    logic        eai_csr_valid;
    logic        eai_csr_ready;
    logic [11:0] eai_csr_addr;
    logic        eai_csr_wr;
    logic [31:0] eai_csr_wdata;
    logic [31:0] eai_csr_rdata;
    logic        acc_busy;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    e203_eai_csr_slv #(.ACC_LAT(3), .XLEN(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_xs_off    (cfg_xs_off),
        .eai_xs_off    (eai_xs_off),
        .eai_csr_valid (eai_csr_valid),
        .eai_csr_ready (eai_csr_ready),
        .eai_csr_addr  (eai_csr_addr),
        .eai_csr_wr    (eai_csr_wr),
        .eai_csr_wdata (eai_csr_wdata),
        .eai_csr_rdata (eai_csr_rdata),
        .acc_busy      (acc_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Starts a new cycle: drive at the falling edge, settle, return mid-cycle.
    task automatic drive(input logic v, input logic [11:0] a, input logic w, input logic [31:0] d);
        @(negedge clk);
        eai_csr_valid = v;
        eai_csr_addr  = a;
        eai_csr_wr    = w;
        eai_csr_wdata = d;
        #1;
    endtask

    initial begin
        rst           = 1'b1;
        cfg_xs_off    = 1'b1;
        eai_csr_valid = 1'b0;
        eai_csr_addr  = 12'hE00;
        eai_csr_wr    = 1'b0;
        eai_csr_wdata = '0;

        drive(0, 12'hE00, 0, 0);
        check("rst_ready",  32'(eai_csr_ready), 32'd1);
        check("rst_busy",   32'(acc_busy),      32'd0);
        check("rst_xs_off", 32'(eai_xs_off),    32'd1);
        check("rst_rdata",  eai_csr_rdata,      32'd0);
        rst = 1'b0;

        // Scratch write shows old value, then read returns new value.
        drive(1, 12'hE04, 1, 32'hDEAD_BEEF);
        check("scr2_wr_ready", 32'(eai_csr_ready), 32'd1);
        check("scr2_wr_old",   eai_csr_rdata,      32'd0);
        drive(1, 12'hE04, 0, 0);
        check("scr2_rd", eai_csr_rdata, 32'hDEAD_BEEF);

        // Accumulator: write 5, stall three cycles, then read 5.
        drive(1, 12'hE0A, 1, 32'd5);
        check("acc_wr_ready", 32'(eai_csr_ready), 32'd1);
        check("acc_wr_old",   eai_csr_rdata,      32'd0);
        drive(1, 12'hE0A, 0, 0);
        check("acc_t1_ready", 32'(eai_csr_ready), 32'd0);
        check("acc_t1_busy",  32'(acc_busy),      32'd1);
        drive(1, 12'hE0A, 0, 0);
        check("acc_t2_ready", 32'(eai_csr_ready), 32'd0);
        drive(1, 12'hE0A, 0, 0);
        check("acc_t3_ready", 32'(eai_csr_ready), 32'd0);
        drive(1, 12'hE0A, 0, 0);
        check("acc_t4_ready", 32'(eai_csr_ready), 32'd1);
        check("acc_t4_busy",  32'(acc_busy),      32'd0);
        check("acc_t4_rdata", eai_csr_rdata,      32'd5);

        // 5 + 0xFFFFFFFF wraps to 4.
        drive(1, 12'hE0A, 1, 32'hFFFF_FFFF);
        drive(0, 12'hE00, 0, 0);
        drive(0, 12'hE00, 0, 0);
        drive(0, 12'hE00, 0, 0);
        drive(1, 12'hE0A, 0, 0);
        check("acc_wrap_ready", 32'(eai_csr_ready), 32'd1);
        check("acc_wrap",       eai_csr_rdata,      32'd4);

        // ECTL keeps only bit 0.
        drive(1, 12'hE00, 1, 32'hFFFF_FFFF);
        drive(1, 12'hE00, 0, 0);
        check("ectl_rd", eai_csr_rdata, 32'd1);

        // Counter carry from low to high half.
        drive(1, 12'hE08, 1, 32'hFFFF_FFFE);
        drive(1, 12'hE09, 1, 32'd0);
        drive(1, 12'hE08, 0, 0);
        check("cyc_lo_fe", eai_csr_rdata, 32'hFFFF_FFFE);
        drive(1, 12'hE08, 0, 0);
        check("cyc_lo_ff", eai_csr_rdata, 32'hFFFF_FFFF);
        drive(1, 12'hE09, 0, 0);
        check("cyc_hi_carry", eai_csr_rdata, 32'd1);
        drive(1, 12'hE08, 0, 0);
        check("cyc_lo_after", eai_csr_rdata, 32'd1);

        // Low-half load in the carry cycle suppresses the carry.
        drive(1, 12'hE08, 1, 32'hFFFF_FFFE);
        drive(1, 12'hE09, 1, 32'd0);
        check("cyc_hi_old", eai_csr_rdata, 32'd1);
        drive(0, 12'hE00, 0, 0);
        drive(1, 12'hE08, 1, 32'h1234_5678);
        check("cyc_carry_old", eai_csr_rdata, 32'hFFFF_FFFF);
        drive(1, 12'hE09, 0, 0);
        check("cyc_hi_nocarry", eai_csr_rdata, 32'd0);
        drive(1, 12'hE08, 0, 0);
        check("cyc_lo_loaded", eai_csr_rdata, 32'h1234_5679);

        // Unmapped accesses count; writes to ERRCNT do not.
        drive(1, 12'hE7F, 0, 0);
        check("unmapped_rd", eai_csr_rdata, 32'd0);
        drive(1, 12'hE0B, 0, 0);
        check("errcnt_1", eai_csr_rdata, 32'd1);
        drive(1, 12'hE0B, 1, 32'h55);
        drive(1, 12'hE0B, 0, 0);
        check("errcnt_wr_ign", eai_csr_rdata, 32'd1);
        drive(1, 12'hE06, 1, 32'hAAAA);
        check("unmapped_wr", eai_csr_rdata, 32'd0);
        drive(1, 12'hE0B, 0, 0);
        check("errcnt_2", eai_csr_rdata, 32'd2);
        drive(1, 12'hE04, 0, 0);
        check("scr2_kept", eai_csr_rdata, 32'hDEAD_BEEF);

        // Valid held then dropped while BUSY: no handshake, no count.
        drive(1, 12'hE0A, 1, 32'd1);
        drive(1, 12'hE7F, 0, 0);
        check("drop_t1_ready", 32'(eai_csr_ready), 32'd0);
        drive(1, 12'hE7F, 0, 0);
        check("drop_t2_ready", 32'(eai_csr_ready), 32'd0);
        drive(0, 12'hE00, 0, 0);
        drive(1, 12'hE0B, 0, 0);
        check("drop_ready", 32'(eai_csr_ready), 32'd1);
        check("drop_errcnt", eai_csr_rdata, 32'd2);
        drive(1, 12'hE0A, 0, 0);
        check("drop_acc", eai_csr_rdata, 32'd5);

        // Saturation of ERRCNT.
        drive(0, 12'hE00, 0, 0);
        force dut.errcnt_q = 32'hFFFF_FFFF;
        drive(0, 12'hE00, 0, 0);
        release dut.errcnt_q;
        drive(1, 12'hE01, 0, 0);
        check("unmapped_e01", eai_csr_rdata, 32'd0);
        drive(1, 12'hE0B, 0, 0);
        check("errcnt_sat", eai_csr_rdata, 32'hFFFF_FFFF);

        // xs_off follows cfg one cycle later.
        drive(0, 12'hE00, 0, 0);
        cfg_xs_off = 1'b0;
        #1;
        check("xs_off_hold", 32'(eai_xs_off), 32'd1);
        drive(0, 12'hE00, 0, 0);
        check("xs_off_fall", 32'(eai_xs_off), 32'd0);

        // Reset during BUSY: immediate idle, no late commit.
        drive(1, 12'hE0A, 1, 32'h10);
        drive(0, 12'hE00, 0, 0);
        check("mid_busy_ready", 32'(eai_csr_ready), 32'd0);
        rst = 1'b1;
        #1;
        check("mid_rst_ready",  32'(eai_csr_ready), 32'd1);
        check("mid_rst_busy",   32'(acc_busy),      32'd0);
        check("mid_rst_xs_off", 32'(eai_xs_off),    32'd1);
        eai_csr_valid = 1'b1;
        eai_csr_addr  = 12'hE0A;
        #1;
        check("mid_rst_acc", eai_csr_rdata, 32'd0);
        eai_csr_addr = 12'hE04;
        #1;
        check("mid_rst_scr2", eai_csr_rdata, 32'd0);
        drive(0, 12'hE00, 0, 0);
        drive(0, 12'hE00, 0, 0);
        rst = 1'b0;
        drive(0, 12'hE00, 0, 0);
        drive(0, 12'hE00, 0, 0);
        drive(0, 12'hE00, 0, 0);
        drive(0, 12'hE00, 0, 0);
        drive(1, 12'hE0A, 0, 0);
        check("post_rst_ready", 32'(eai_csr_ready), 32'd1);
        check("post_rst_acc",   eai_csr_rdata,      32'd0);
        drive(1, 12'hE0B, 0, 0);
        check("post_rst_errcnt", eai_csr_rdata, 32'd0);
        drive(1, 12'hE08, 0, 0);
        check("post_rst_cyc", eai_csr_rdata, 32'd0);
        drive(0, 12'hE00, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/e203_eai_csr_slv.md
Name: e203_eai_csr_slv

Overview:
- Responder end of the EAI CSR interface. Sits in the coprocessor/extension unit and serves custom CSR accesses in the 0xE00-0xEFF range that the EXU CSR control block issues.
- Provides a control register, scratch registers, a 64-bit cycle counter, a multi-cycle accumulator and an unmapped-access error counter.
- Read data returns combinationally in the handshake cycle. Accumulator writes stall the interface for ACC_LAT cycles.

Parameters:
ACC_LAT, 3, accumulator commit latency in cycles; legal range 1..15
XLEN, 32, data width; fixed at 32

Ports:
clk  input  1  clock
rst  input  1  reset; asynchronous, active-high
cfg_xs_off  input  1  system request to switch the extension state off
eai_xs_off  output  1  registered copy of cfg_xs_off; 1 = initiator must not route CSR accesses here
eai_csr_valid  input  1  request valid; may drop without a handshake
eai_csr_ready  output  1  request accept
eai_csr_addr  input  12  CSR index; bits [11:8] are always 4'hE when valid
eai_csr_wr  input  1  1 = write request
eai_csr_wdata  input  32  write data
eai_csr_rdata  output  32  read data; must be valid in the handshake cycle
acc_busy  output  1  accumulator commit in progress

Behaviour:
- Handshake: hs = eai_csr_valid & eai_csr_ready.
  - eai_csr_ready = (state==IDLE). It must not depend combinationally on valid, addr or wr.
  - A valid that falls without hs has no effect on any state.
- Read data: eai_csr_rdata is a combinational mux of eai_csr_addr, driven whenever valid is high. It shows the pre-write value during a write hs.
- CSR map (addr[7:0]):
  - 0x00 ECTL: bit0 cnt_en, reset 0; other bits read 0.
  - 0x02-0x05 SCR0-SCR3: R/W, reset 0.
  - 0x08 ECYCLE: cycle counter [31:0].
  - 0x09 ECYCLEH: cycle counter [63:32].
  - 0x0A EACC: read returns acc; write starts an accumulate.
  - 0x0B ERRCNT: read-only count of unmapped accesses.
  - Any other address: unmapped; ready follows the normal rule, rdata=0, write ignored.
- Cycle counter (64-bit):
  - Increments by 1 each cycle while cnt_en=1.
  - Wraps from 0xFFFF_FFFF_FFFF_FFFF to 0.
  - A write hs to ECYCLE or ECYCLEH loads that half. In that cycle the load wins over the increment for the whole 64-bit value: the other half holds and no carry is applied.
- ERRCNT:
  - +1 per unmapped hs, whether read or write.
  - Saturates at 0xFFFF_FFFF.
  - Writes to 0x0B are ignored and are not counted.
- Accumulator FSM, states IDLE and BUSY:
  - IDLE -> BUSY on a write hs to EACC: latch wdata as addend and load cnt=ACC_LAT-1.
  - BUSY: ready=0 and acc_busy=1; cnt decrements each cycle.
  - When cnt==0 in BUSY: acc <= acc + addend (mod 2^32, carry dropped), then -> IDLE.
  - Timing for a write hs at cycle T: ready low for T+1..T+ACC_LAT; new acc readable at T+ACC_LAT+1.
  - A read of EACC in IDLE returns the committed acc.
- Counters run during BUSY; cycle counting is not stalled.
- eai_xs_off <= cfg_xs_off every cycle; reset value 1. The slave still responds normally while xs_off=1; gating is the initiator's job.
- Reset (async, any time, including mid-BUSY):
  - state=IDLE, acc=0, pending addend discarded.
  - SCRx=0, ECTL=0, counter=0, ERRCNT=0.
  - eai_csr_ready=1, acc_busy=0, eai_xs_off=1.
  - eai_csr_rdata follows addr and is 0 when valid=0.

Test Plan:
- Reset, then write SCR2=0xDEAD_BEEF; read SCR2 -> rdata 0xDEADBEEF in the hs cycle. A write hs shows the old value (0) on rdata.
- ACC_LAT=3: write EACC=5 at T, then present a read of EACC from T+1 -> ready=0 at T+1..T+3, hs at T+4 with rdata 5. Write EACC=0xFFFF_FFFF -> acc=4 (wrap).
- Set cnt_en=1, write ECYCLE=0xFFFF_FFFE, ECYCLEH=0 -> after 2 cycles ECYCLEH reads 1. A write to ECYCLE in the carry cycle loads the written value and ECYCLEH stays 0.
- Access 0xE7F and then 0xE0B -> rdata 0 and ERRCNT=1. Force ERRCNT to 0xFFFF_FFFF, do another unmapped access -> stays 0xFFFF_FFFF.
- Assert valid for 2 cycles while BUSY, then drop it before hs -> no state change, ERRCNT unchanged.
- Assert rst at T+1 after an EACC write -> ready=1 and acc=0 immediately; no late commit. cfg_xs_off=0 -> eai_xs_off falls one cycle later.
